div_sched: RTL and testbench
============================

Name: div_sched

Overview:
- Time-shares one sequential `divider` (start/ready handshake) between up to R requesters: instantaneous speed, average speed, cadence and trip distance.
- Round-robin arbitration, operand muxing and divider start sequencing.
- Captures quotient/remainder and returns them to the owning requester with a one-cycle done pulse.
- Sits between the cycle-computer measurement blocks and the single shared divider instance.

Parameters:
- N, 64, operand/result width in bits.
- R, 4, number of requesters (2..8).
- TIMEOUT, 256, max cycles in WAIT before the operation is aborted.

Ports:
- clock  in  1  system clock
- Rst  in  1  synchronous active-high reset
- req  in  R  per-requester request level; held until matching done
- dividend  in  R*N  flattened; slice i = requester i dividend
- divisor  in  R*N  flattened; slice i = requester i divisor
- grant  out  R  one-hot owner of the divider; all-zero when idle
- done  out  R  one-cycle pulse to the owner; result valid this cycle
- quotient  out  N  result bus; valid while done is nonzero
- remainder  out  N  result bus; valid while done is nonzero
- err  out  2  status with done: 00 ok, 01 divide-by-zero, 10 timeout
- div_start  out  1  one-cycle start pulse to the divider
- div_dividend  out  N  registered operand to the divider
- div_divisor  out  N  registered operand to the divider
- div_quot  in  N  divider quotient
- div_rem  in  N  divider remainder
- div_ready  in  1  divider result valid; first high cycle in WAIT is used

Behaviour:
- Reset (Rst high at a clock edge):
  - state=IDLE; grant=0; done=0; quotient=0; remainder=0; err=0; div_start=0; div_dividend=0; div_divisor=0.
  - Round-robin pointer=0. Wait counter=0.
  - Applies mid-operation: the in-flight result is discarded, no done is issued, and any later div_ready is ignored until a new start.
- State IDLE:
  - If any req bit is set, pick the first set bit searching from the pointer upward, wrapping modulo R.
  - Register grant one-hot, latch that requester's dividend and divisor.
  - Go to LOAD.
  - No req: stay in IDLE with grant=0.
- State LOAD (one cycle):
  - Divisor==0: skip the divider. Next cycle: quotient={N{1}}, remainder=dividend, err=01, done[owner]=1. Go to IDLE.
  - Otherwise: drive div_dividend/div_divisor; div_start=1 for exactly this cycle; clear the wait counter; go to WAIT.
- State WAIT:
  - Operands stay stable; the counter increments each cycle.
  - On div_ready=1: register quotient=div_quot, remainder=div_rem, err=00, done[owner]=1 next cycle. Go to IDLE.
  - If the counter reaches TIMEOUT-1 without ready: quotient=0, remainder=0, err=10, done[owner]=1. Go to IDLE.
  - div_ready and timeout in the same cycle: ready wins.
- Done cycle:
  - grant drops in the same cycle done is asserted.
  - Pointer becomes owner+1 mod R.
  - The scheduler is in IDLE and may accept a new request on the following edge.
- Latency: request seen in IDLE at cycle t → grant at t+1, div_start at t+2, done one cycle after div_ready. Divide-by-zero: done at t+3.
- Requesters:
  - A requester deasserting req while owner does not cancel the operation; done and the result are still delivered.
  - req is only sampled in IDLE.
  - The owner must hold its operands until done; the scheduler latches them in IDLE anyway.
- Output hold rules:
  - quotient, remainder and err hold their last values between done pulses.
  - done is never asserted for more than one requester or for more than one cycle.
- div_ready outside WAIT is ignored.

Decomposition:
- Package `div_sched_pkg`:
  - state enum {IDLE, LOAD, WAIT} as logic [1:0];
  - err encoding constants ERR_OK, ERR_DZ, ERR_TO.
- Sub-module `rr_pick`: combinational round-robin picker (req, ptr → one-hot grant, index), parameterised on R.
- The existing `divider` is instantiated by the parent, not inside this block.

Test Plan:
- Single request: req[0], dividend 100, divisor 7, divider model with ready 66 cycles after start → grant=0001 one cycle later, one div_start pulse, done[0] with quotient 14, remainder 2, err 00.
- Contention: req=1011 held, pointer 0 → service order 0,1,3,0; each done carries its own operands' result (e.g. 46080000/12800 = 3600, remainder 0).
- Fairness wrap: pointer at 3, req=1001 → requester 3 first, then 0, then pointer=1.
- Divide-by-zero: req[2], dividend 55, divisor 0 → no div_start, done[2] at t+3, quotient all-ones, remainder 55, err 01.
- Timeout: TIMEOUT=16, divider never readies → done after 16 WAIT cycles, quotient 0, err 10; a late div_ready is ignored.
- Reset mid-WAIT: Rst for 1 cycle → all outputs 0, no done, a subsequent div_ready ignored; a new req serviced normally with pointer 0.

Source files
------------

// File: rtl/div_sched_pkg.sv
// Shared types for the divider scheduler: FSM states and result status codes.
package div_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    WAIT = 2'b10
  } state_t;

  localparam logic [1:0] ERR_OK = 2'b00;
  localparam logic [1:0] ERR_DZ = 2'b01;
  localparam logic [1:0] ERR_TO = 2'b10;

endpackage

// File: rtl/div_sched_rr_pick.sv
// Combinational round-robin picker: first set request at or above the pointer, wrapping.
module rr_pick #(
  parameter int R  = 4,
  parameter int IW = (R > 1) ? $clog2(R) : 1
) (
  input  logic [R-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [R-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [IW-1:0] w_idx;

  // Scan R positions starting at the pointer; the first hit wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < R; k++) begin
      w_idx = IW'((int'(i_ptr) + k) % R);
      if (!o_any && i_req[w_idx]) begin
        o_any          = 1'b1;
        o_idx          = w_idx;
        o_grant[w_idx] = 1'b1;
      end else begin
        o_any = o_any;
      end
    end
  end

endmodule

// File: rtl/div_sched.sv
// Time-shares one start/ready sequential divider between R requesters with
// round-robin arbitration, divide-by-zero bypass and a WAIT timeout.
module div_sched
  import div_sched_pkg::*;
#(
  parameter int N       = 64,
  parameter int R       = 4,
  parameter int TIMEOUT = 256
) (
  input  logic           clock,
  input  logic           Rst,
  input  logic [R-1:0]   req,
  input  logic [R*N-1:0] dividend,
  input  logic [R*N-1:0] divisor,
  output logic [R-1:0]   grant,
  output logic [R-1:0]   done,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic [1:0]     err,
  output logic           div_start,
  output logic [N-1:0]   div_dividend,
  output logic [N-1:0]   div_divisor,
  input  logic [N-1:0]   div_quot,
  input  logic [N-1:0]   div_rem,
  input  logic           div_ready
);

  localparam int IW = $clog2(R);
  localparam int CW = $clog2(TIMEOUT) + 1;

  state_t        r_state, w_state_nx;
  logic [R-1:0]  r_grant, w_grant_nx, r_done, w_done_nx;
  logic [IW-1:0] r_owner, w_owner_nx, r_ptr, w_ptr_nx;
  logic [N-1:0]  r_a, w_a_nx, r_b, w_b_nx;
  logic [N-1:0]  r_quot, w_quot_nx, r_rem, w_rem_nx;
  logic [N-1:0]  r_div_a, w_div_a_nx, r_div_b, w_div_b_nx;
  logic [1:0]    r_err, w_err_nx;
  logic          r_start, w_start_nx, r_dz, w_dz_nx, w_fin;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic [R-1:0]  w_pick_grant;
  logic [IW-1:0] w_pick_idx;
  logic          w_pick_any;

  rr_pick #(.R(R), .IW(IW)) u_pick (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );

  // Next-state and next-register values for the whole scheduler.
  always_comb begin
    w_state_nx = r_state;
    w_grant_nx = r_grant;
    w_done_nx  = '0;
    w_owner_nx = r_owner;
    w_ptr_nx   = r_ptr;
    w_a_nx     = r_a;
    w_b_nx     = r_b;
    w_quot_nx  = r_quot;
    w_rem_nx   = r_rem;
    w_div_a_nx = r_div_a;
    w_div_b_nx = r_div_b;
    w_err_nx   = r_err;
    w_start_nx = 1'b0;
    w_dz_nx    = r_dz;
    w_cnt_nx   = r_cnt;
    w_fin      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_any) begin
          w_grant_nx = w_pick_grant;
          w_owner_nx = w_pick_idx;
          w_a_nx     = dividend[int'(w_pick_idx)*N +: N];
          w_b_nx     = divisor[int'(w_pick_idx)*N +: N];
          w_state_nx = LOAD;
        end else begin
          w_grant_nx = '0;
        end
      end
      LOAD: begin
        w_cnt_nx   = '0;
        w_state_nx = WAIT;
        // A zero divisor bypasses the divider and completes from the first WAIT cycle.
        if (r_b == {N{1'b0}}) begin
          w_dz_nx = 1'b1;
        end else begin
          w_dz_nx    = 1'b0;
          w_div_a_nx = r_a;
          w_div_b_nx = r_b;
          w_start_nx = 1'b1;
        end
      end
      WAIT: begin
        w_cnt_nx = r_cnt + CW'(1);
        if (r_dz) begin
          w_fin     = 1'b1;
          w_quot_nx = {N{1'b1}};
          w_rem_nx  = r_a;
          w_err_nx  = ERR_DZ;
        end else if (div_ready) begin
          w_fin     = 1'b1;
          w_quot_nx = div_quot;
          w_rem_nx  = div_rem;
          w_err_nx  = ERR_OK;
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_fin     = 1'b1;
          w_quot_nx = {N{1'b0}};
          w_rem_nx  = {N{1'b0}};
          w_err_nx  = ERR_TO;
        end else begin
          w_fin = 1'b0;
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_grant_nx = '0;
      end
    endcase
    if (w_fin) begin
      w_done_nx  = r_grant;
      w_grant_nx = '0;
      w_dz_nx    = 1'b0;
      w_ptr_nx   = (r_owner == IW'(R - 1)) ? '0 : r_owner + IW'(1);
      w_state_nx = IDLE;
    end else begin
      w_done_nx = '0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (Rst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_done  <= '0;
      r_owner <= '0;
      r_ptr   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_div_a <= '0;
      r_div_b <= '0;
      r_err   <= ERR_OK;
      r_start <= 1'b0;
      r_dz    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_grant <= w_grant_nx;
      r_done  <= w_done_nx;
      r_owner <= w_owner_nx;
      r_ptr   <= w_ptr_nx;
      r_a     <= w_a_nx;
      r_b     <= w_b_nx;
      r_quot  <= w_quot_nx;
      r_rem   <= w_rem_nx;
      r_div_a <= w_div_a_nx;
      r_div_b <= w_div_b_nx;
      r_err   <= w_err_nx;
      r_start <= w_start_nx;
      r_dz    <= w_dz_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  assign grant        = r_grant;
  assign done         = r_done;
  assign quotient     = r_quot;
  assign remainder    = r_rem;
  assign err          = r_err;
  assign div_start    = r_start;
  assign div_dividend = r_div_a;
  assign div_divisor  = r_div_b;

endmodule

// File: tb/tb_div_sched.sv
// Directed bench for div_sched with a behavioural start/ready divider model.
module tb_div_sched;

  localparam int N  = 64;
  localparam int R  = 4;
  localparam int TO = 256;

  logic           clock = 1'b0;
  logic           Rst = 1'b1;
  logic [R-1:0]   req = '0;
  logic [R*N-1:0] dividend = '0;
  logic [R*N-1:0] divisor = '0;
  logic [R-1:0]   grant, done;
  logic [N-1:0]   quotient, remainder, div_dividend, div_divisor;
  logic [1:0]     err;
  logic           div_start;
  logic [N-1:0]   div_quot = '0;
  logic [N-1:0]   div_rem = '0;
  logic           div_ready = 1'b0;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int poke_at = -1;
  int m_dly = 66;
  bit m_en = 1'b1;
  bit m_busy = 1'b0;
  int m_cnt = 0;
  logic [N-1:0] m_a = '0, m_b = '0;
  int viol = 0;
  logic [R-1:0] prev_done = '0;

  div_sched #(.N(N), .R(R), .TIMEOUT(TO)) dut (
    .clock(clock), .Rst(Rst), .req(req), .dividend(dividend), .divisor(divisor),
    .grant(grant), .done(done), .quotient(quotient), .remainder(remainder), .err(err),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quot(div_quot), .div_rem(div_rem), .div_ready(div_ready)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Divider model: ready m_dly cycles after start, or a forced pulse at cycle poke_at.
  always @(negedge clock) begin
    div_ready = 1'b0;
    if (cyc == poke_at) begin
      div_ready = 1'b1;
      div_quot  = 64'd99;
      div_rem   = 64'd98;
    end else if (div_start) begin
      m_busy = m_en;
      m_cnt  = m_dly;
      m_a    = div_dividend;
      m_b    = div_divisor;
    end else if (m_busy) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        div_ready = 1'b1;
        div_quot  = m_a / m_b;
        div_rem   = m_a % m_b;
        m_busy    = 1'b0;
      end
    end
  end

  // done must be one-hot-or-zero and never last two cycles.
  always @(negedge clock) begin
    if ($countones(done) > 1 || (done != '0 && prev_done != '0)) viol <= viol + 1;
    prev_done <= done;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_op(input int i, input logic [63:0] a, input logic [63:0] b);
    dividend[i*N +: N] = a;
    divisor[i*N +: N]  = b;
  endtask

  task automatic wait_done(input string tag, input int limit, output int n);
    n = 0;
    while (done == '0 && n < limit) begin
      tick();
      n++;
    end
    if (done == '0) check_eq({tag, "_bound"}, 64'd0, 64'd1);
  endtask

  task automatic check_result(input string tag, input logic [R-1:0] g, input logic [63:0] q,
                              input logic [63:0] r, input logic [1:0] e);
    check_eq({tag, "_done"}, 64'(done), 64'(g));
    check_eq({tag, "_quot"}, quotient, q);
    check_eq({tag, "_rem"}, remainder, r);
    check_eq({tag, "_err"}, 64'(err), 64'(e));
    check_eq({tag, "_grant0"}, 64'(grant), 64'd0);
  endtask

  logic [R-1:0] exp_g [4] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
  logic [63:0]  exp_q [4] = '{64'd3600, 64'd30, 64'd123, 64'd3600};
  logic [63:0]  exp_r [4] = '{64'd0, 64'd10, 64'd45, 64'd0};

  initial begin
    int n;
    int cnt_done;
    repeat (3) tick();
    check_eq("rst_grant", 64'(grant), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_quot", quotient, 64'd0);
    check_eq("rst_rem", remainder, 64'd0);
    check_eq("rst_err", 64'(err), 64'd0);
    check_eq("rst_start", 64'(div_start), 64'd0);
    check_eq("rst_ops", div_dividend | div_divisor, 64'd0);
    Rst = 1'b0;
    tick();

    // Single request, divider ready 66 cycles after start.
    set_op(0, 64'd100, 64'd7);
    req = 4'b0001;
    tick();
    check_eq("s_grant", 64'(grant), 64'd1);
    check_eq("s_nostart", 64'(div_start), 64'd0);
    tick();
    check_eq("s_start", 64'(div_start), 64'd1);
    check_eq("s_opa", div_dividend, 64'd100);
    check_eq("s_opb", div_divisor, 64'd7);
    tick();
    check_eq("s_start_pulse", 64'(div_start), 64'd0);
    wait_done("s", 200, n);
    check_eq("s_latency", 64'(n), 64'd66);
    check_result("s", 4'b0001, 64'd14, 64'd2, 2'b00);
    req = 4'b0000;
    tick();
    check_eq("s_done_pulse", 64'(done), 64'd0);
    check_eq("s_hold", quotient, 64'd14);

    // Contention from pointer 0: order 0,1,3,0.
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    m_dly = 3;
    set_op(0, 64'd46080000, 64'd12800);
    set_op(1, 64'd1000, 64'd33);
    set_op(3, 64'd12345, 64'd100);
    req = 4'b1011;
    tick();
    check_eq("c_grant0", 64'(grant), 64'(exp_g[0]));
    for (int i = 0; i < 4; i++) begin
      wait_done("c", 50, n);
      check_result($sformatf("c%0d", i), exp_g[i], exp_q[i], exp_r[i], 2'b00);
      if (i == 3) req = 4'b0000;
      tick();
      if (i < 3) check_eq($sformatf("c_grant%0d", i + 1), 64'(grant), 64'(exp_g[i + 1]));
    end

    // Move the pointer to 3, then check the wrap 3 -> 0 -> pointer 1.
    set_op(2, 64'd81, 64'd9);
    req = 4'b0100;
    tick();
    wait_done("p", 50, n);
    check_result("p", 4'b0100, 64'd9, 64'd0, 2'b00);
    req = 4'b1001;
    tick();
    check_eq("w_grant3", 64'(grant), 64'd8);
    wait_done("w3", 50, n);
    check_result("w3", 4'b1000, 64'd123, 64'd45, 2'b00);
    tick();
    check_eq("w_grant0", 64'(grant), 64'd1);
    wait_done("w0", 50, n);
    check_result("w0", 4'b0001, 64'd3600, 64'd0, 2'b00);
    req = 4'b0011;
    tick();
    check_eq("w_ptr1", 64'(grant), 64'd2);
    wait_done("w1", 50, n);
    check_result("w1", 4'b0010, 64'd30, 64'd10, 2'b00);
    req = 4'b0000;
    tick();

    // Divide by zero: no start, done at t+3.
    set_op(2, 64'd55, 64'd0);
    req = 4'b0100;
    tick();
    check_eq("dz_grant", 64'(grant), 64'd4);
    check_eq("dz_done1", 64'(done), 64'd0);
    tick();
    check_eq("dz_nostart", 64'(div_start), 64'd0);
    check_eq("dz_done2", 64'(done), 64'd0);
    tick();
    check_result("dz", 4'b0100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd55, 2'b01);
    req = 4'b0000;
    tick();
    check_eq("dz_pulse", 64'(done), 64'd0);

    // Timeout: the divider never answers.
    m_en = 1'b0;
    set_op(1, 64'd5, 64'd1);
    req = 4'b0010;
    tick();
    tick();
    check_eq("to_start", 64'(div_start), 64'd1);
    wait_done("to", TO + 20, n);
    check_eq("to_cycles", 64'(n), 64'(TO));
    check_result("to", 4'b0010, 64'd0, 64'd0, 2'b10);
    req = 4'b0000;
    poke_at = cyc + 2;
    cnt_done = 0;
    repeat (6) begin
      tick();
      if (done != '0) cnt_done++;
    end
    check_eq("to_late_ready", 64'(cnt_done), 64'd0);
    check_eq("to_hold_err", 64'(err), 64'd2);
    m_en = 1'b1;

    // Reset in the middle of WAIT; the stale ready must be ignored.
    m_dly = 20;
    set_op(2, 64'd81, 64'd9);
    req = 4'b0100;
    tick();
    tick();
    check_eq("r_start", 64'(div_start), 64'd1);
    tick();
    tick();
    Rst = 1'b1;
    req = 4'b0000;
    tick();
    Rst = 1'b0;
    check_eq("r_grant", 64'(grant), 64'd0);
    check_eq("r_done", 64'(done), 64'd0);
    check_eq("r_ops", div_dividend | div_divisor, 64'd0);
    check_eq("r_out", quotient | remainder | 64'(err), 64'd0);
    cnt_done = 0;
    repeat (25) begin
      tick();
      if (done != '0) cnt_done++;
    end
    check_eq("r_stale_ready", 64'(cnt_done), 64'd0);
    set_op(1, 64'd1000, 64'd33);
    set_op(3, 64'd12345, 64'd100);
    req = 4'b1010;
    tick();
    check_eq("r_ptr0", 64'(grant), 64'd2);
    wait_done("r", 50, n);
    check_result("r", 4'b0010, 64'd30, 64'd10, 2'b00);
    req = 4'b0000;
    tick();
    tick();
    check_eq("done_onehot_pulse", 64'(viol), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
